// File: rtl/dmem_responder.sv
// dmem_responder: word-organised data memory serving the Memory stage with a
// fixed per-access wait (LATENCY) and byte/half/word lane selection.
// Optional build macro DMEM_MISALIGN_CHK_EN: when defined, requests whose lanes
// spill past the word boundary are suppressed and flagged on o_err; when
// undefined, o_err stays 0 and overflowing lanes are simply dropped.

`ifndef N
`define N 32
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module dmem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_addr_vld,
  input  logic [`ADDR_WIDTH-1:0] i_addr,
  input  logic                   i_wr_en,
  input  logic [3:0]             i_sel,
  input  logic [`N-1:0]          i_wdata,
  output logic [`N-1:0]          o_rdata,
  output logic                   o_d_valid,
  output logic                   o_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          dvld_q, dvld_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [31:0]   pend_q, pend_d;
  logic          pend_ld_q, pend_ld_d;
  logic          pend_err_q, pend_err_d;
  logic          err_q, err_d;

  logic [31:0]   mem [DEPTH];

  logic          acc;
  logic [AW-1:0] idx;
  logic [1:0]    off;
  logic [7:0]    lanes_wide;
  logic [3:0]    lanes;
  logic          mis;
  logic [31:0]   word;
  logic [31:0]   ld_data;
  logic [31:0]   wshift;

  // Upper address bits are deliberately ignored so accesses wrap.
  generate
    if (`ADDR_WIDTH > AW + 2) begin : g_unused_addr
      logic unused_addr_hi;
      assign unused_addr_hi = ^i_addr[`ADDR_WIDTH-1:AW+2];
    end
  endgenerate

  // o_d_valid is the registered "ready" flag, so it doubles as the accept gate.
  assign acc        = i_addr_vld & dvld_q;
  assign idx        = i_addr[AW+1:2];
  assign off        = i_addr[1:0];
  assign lanes_wide = {4'b0, i_sel} << off;
  assign lanes      = lanes_wide[3:0];
`ifdef DMEM_MISALIGN_CHK_EN
  assign mis        = |lanes_wide[7:4];
`else
  assign mis        = 1'b0;
`endif

  assign word    = mem[idx];
  assign ld_data = (word >> {off, 3'b000}) &
                   {{8{i_sel[3]}}, {8{i_sel[2]}}, {8{i_sel[1]}}, {8{i_sel[0]}}};
  assign wshift  = i_wdata << {off, 3'b000};

  // Store commits on the accept edge; array contents survive reset.
  always_ff @(posedge clk) begin
    if (acc && i_wr_en && !mis) begin
      for (int b = 0; b < 4; b++) begin
        if (lanes[b]) mem[idx][8*b +: 8] <= wshift[8*b +: 8];
      end
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      dvld_q     <= 1'b1;
      rdata_q    <= 32'd0;
      pend_q     <= 32'd0;
      pend_ld_q  <= 1'b0;
      pend_err_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dvld_q     <= dvld_d;
      rdata_q    <= rdata_d;
      pend_q     <= pend_d;
      pend_ld_q  <= pend_ld_d;
      pend_err_q <= pend_err_d;
      err_q      <= err_d;
    end
  end

  // Next state: load data is captured at accept and released when the wait ends.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dvld_d     = dvld_q;
    rdata_d    = rdata_q;
    pend_d     = pend_q;
    pend_ld_d  = pend_ld_q;
    pend_err_d = pend_err_q;
    err_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (acc) begin
          if (LATENCY == 0) begin
            if (!i_wr_en && !mis) rdata_d = ld_data;
            err_d = mis;
          end else begin
            state_d    = WAIT;
            cnt_d      = LAT_M1;
            dvld_d     = 1'b0;
            pend_d     = ld_data;
            pend_ld_d  = !i_wr_en && !mis;
            pend_err_d = mis;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = IDLE;
          dvld_d  = 1'b1;
          if (pend_ld_q) rdata_d = pend_q;
          err_d   = pend_err_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        dvld_d  = 1'b1;
      end
    endcase
  end

  assign o_rdata   = rdata_q;
  assign o_d_valid = dvld_q;
  assign o_err     = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (LATENCY 0/1/3) share one request
// stream and are checked against a byte-addressed reference memory.
module tb_dmem_responder;

`ifdef DMEM_MISALIGN_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  localparam int DEPTH = 1024;
  localparam int NB    = DEPTH * 4;

  logic clk = 1'b0;
  logic rst_n;
  logic vld, wr;
  logic [3:0]  sel;
  logic [31:0] addr, wd;
  logic [2:0]  dv, er;
  logic [2:0][31:0] rd;

  int checks = 0;
  int failures = 0;
  int lat [3] = '{0, 1, 3};
  logic [31:0] exp_rd [3];
  logic [7:0]  mb [NB];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(0)) u_l0 (
    .clk(clk), .rst_n(rst_n), .i_addr_vld(vld), .i_addr(addr), .i_wr_en(wr),
    .i_sel(sel), .i_wdata(wd), .o_rdata(rd[0]), .o_d_valid(dv[0]), .o_err(er[0]));
  dmem_responder #(.DEPTH(DEPTH), .LATENCY(1)) u_l1 (
    .clk(clk), .rst_n(rst_n), .i_addr_vld(vld), .i_addr(addr), .i_wr_en(wr),
    .i_sel(sel), .i_wdata(wd), .o_rdata(rd[1]), .o_d_valid(dv[1]), .o_err(er[1]));
  dmem_responder #(.DEPTH(DEPTH), .LATENCY(3)) u_l3 (
    .clk(clk), .rst_n(rst_n), .i_addr_vld(vld), .i_addr(addr), .i_wr_en(wr),
    .i_sel(sel), .i_wdata(wd), .o_rdata(rd[2]), .o_d_valid(dv[2]), .o_err(er[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: plain byte memory, lanes that fall past byte 3 of the word do not exist.
  function automatic bit misal(input logic [3:0] s, input logic [31:0] a);
    for (int k = 0; k < 4; k++)
      if (s[k] && (int'(a % 4) + k > 3)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] load_m(input logic [3:0] s, input logic [31:0] a);
    int base = int'(a % NB) - int'(a % 4);
    int o = int'(a % 4);
    logic [31:0] r = 32'd0;
    for (int k = 0; k < 4; k++)
      if (s[k] && o + k < 4) r[8*k +: 8] = mb[base + o + k];
    return r;
  endfunction

  task automatic store_m(input logic [3:0] s, input logic [31:0] a, input logic [31:0] d);
    int base = int'(a % NB) - int'(a % 4);
    int o = int'(a % 4);
    if (CHK && misal(s, a)) return;
    for (int k = 0; k < 4; k++)
      if (s[k] && o + k < 4) mb[base + o + k] = d[8*k +: 8];
  endtask

  task automatic wait_ready();
    int n = 0;
    while (dv !== 3'b111 && n < 20) begin @(negedge clk); n++; end
    chk("ready", {29'd0, dv}, 32'h7);
  endtask

  // One request presented for a single cycle; checks valid/rdata/err timing per instance.
  task automatic do_req(input bit we, input logic [3:0] s, input logic [31:0] a,
                        input logic [31:0] d, input bit abort);
    bit m;
    logic [31:0] nr [3];
    wait_ready();
    m = CHK && misal(s, a);
    for (int k = 0; k < 3; k++) nr[k] = (!we && !m) ? load_m(s, a) : exp_rd[k];
    if (we) store_m(s, a, d);
    vld = 1'b1; wr = we; sel = s; addr = a; wd = d;
    @(posedge clk);
    @(negedge clk);
    vld = 1'b0; wr = 1'bx; sel = 'x; addr = 'x; wd = 'x;
    for (int n = 0; n < 4; n++) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("dvalid[L%0d,n%0d]", lat[k], n), {31'd0, dv[k]}, {31'd0, n >= lat[k]});
        chk($sformatf("rdata[L%0d,n%0d]", lat[k], n), rd[k], (n >= lat[k]) ? nr[k] : exp_rd[k]);
        chk($sformatf("err[L%0d,n%0d]", lat[k], n), {31'd0, er[k]}, {31'd0, (n == lat[k]) && m});
      end
      if (abort) begin
        rst_n = 1'b0;
        #1;
        chk("rst_dvalid", {29'd0, dv}, 32'h7);
        chk("rst_err", {29'd0, er}, 32'h0);
        for (int k = 0; k < 3; k++) begin
          chk($sformatf("rst_rdata[L%0d]", lat[k]), rd[k], 32'd0);
          nr[k] = 32'd0;
        end
        @(negedge clk);
        rst_n = 1'b1;
        break;
      end
      if (n < 3) @(negedge clk);
    end
    for (int k = 0; k < 3; k++) exp_rd[k] = nr[k];
  endtask

  function automatic logic [31:0] rnd_addr(input int w, input int o);
    return ($urandom & 32'hFFFF_F000) | (32'(w) << 2) | 32'(o);
  endfunction

  initial begin
    logic [3:0]  sels [3] = '{4'h1, 4'h3, 4'hF};
    logic [31:0] haddr [12];
    int acc3;
    vld = 1'b0; wr = 1'b0; sel = 4'h0; addr = 32'd0; wd = 32'd0;
    for (int k = 0; k < 3; k++) exp_rd[k] = 32'd0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_dvalid", {29'd0, dv}, 32'h7);
    chk("reset_err", {29'd0, er}, 32'h0);
    for (int k = 0; k < 3; k++) chk("reset_rdata", rd[k], 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Word store then load at 0x10.
    do_req(1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 1'b0);
    do_req(1'b0, 4'hF, 32'h10, 32'h0, 1'b0);
    chk("deadbeef", rd[1], 32'hDEADBEEF);

    // Byte merge into a word, then word and byte loads.
    do_req(1'b1, 4'hF, 32'h10, 32'h11223344, 1'b0);
    do_req(1'b1, 4'h1, 32'h13, 32'h000000AA, 1'b0);
    do_req(1'b0, 4'hF, 32'h10, 32'h0, 1'b0);
    chk("byte_merge_word", rd[1], 32'hAA223344);
    do_req(1'b0, 4'h1, 32'h13, 32'h0, 1'b0);
    chk("byte_load", rd[1], 32'h000000AA);

    // Address wrap modulo DEPTH*4.
    do_req(1'b1, 4'hF, 32'h0, 32'h5, 1'b0);
    do_req(1'b0, 4'hF, 32'h1000, 32'h0, 1'b0);
    chk("wrap", rd[2], 32'h5);

    // Word store at 0x22 straddles the word boundary.
    do_req(1'b1, 4'hF, 32'h20, 32'h12345678, 1'b0);
    do_req(1'b1, 4'hF, 32'h22, 32'hCAFEF00D, 1'b0);
    do_req(1'b0, 4'hF, 32'h20, 32'h0, 1'b0);
    chk("misalign_word", rd[0], CHK ? 32'h12345678 : 32'hF00D5678);
    do_req(1'b0, 4'h3, 32'h23, 32'h0, 1'b0);

    // Fill a 16-word window with random contents (random upper bits exercise wrap).
    for (int w = 0; w < 16; w++) do_req(1'b1, 4'hF, rnd_addr(w, 0), $urandom, 1'b0);

    // Random mixed traffic against the model.
    for (int i = 0; i < 60; i++)
      do_req(1'($urandom % 2), sels[$urandom % 3], rnd_addr(int'($urandom % 16), int'($urandom % 4)),
             $urandom, 1'b0);

    // Request valid held high: waiting instances must ignore the stream.
    wait_ready();
    acc3 = 0;
    for (int c = 0; c < 12; c++) begin
      haddr[c] = rnd_addr(int'($urandom % 16), 0);
      vld = 1'b1; wr = 1'b0; sel = 4'hF; addr = haddr[c]; wd = $urandom;
      if (dv[2] === 1'b1) acc3++;
      @(negedge clk);
    end
    vld = 1'b0;
    repeat (4) @(negedge clk);
    chk("held_vld_accepts_L3", 32'(acc3), 32'd3);
    exp_rd[0] = load_m(4'hF, haddr[11]);
    exp_rd[1] = load_m(4'hF, haddr[10]);
    exp_rd[2] = load_m(4'hF, haddr[8]);
    for (int k = 0; k < 3; k++) chk($sformatf("held_vld_rdata[L%0d]", lat[k]), rd[k], exp_rd[k]);

    // Reset during the wait of a load, then of a store; next loads must be normal.
    do_req(1'b0, 4'hF, rnd_addr(3, 0), 32'h0, 1'b1);
    do_req(1'b0, 4'hF, rnd_addr(5, 0), 32'h0, 1'b0);
    do_req(1'b1, 4'hF, rnd_addr(7, 0), 32'hA5A5_0F0F, 1'b1);
    do_req(1'b0, 4'hF, rnd_addr(7, 0), 32'h0, 1'b0);
    chk("store_survives_reset", rd[2], 32'hA5A5_0F0F);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
